// File: rtl/reg_bus_arbiter.sv
// reg_bus_arbiter: shares the byte-wide USB register bus between the host
// frontend (always passed straight through) and one internal word master,
// whose single word request is serialised into consecutive byte cycles.
// Optional feature macro: REG_ARB_PREEMPT_CNT_EN enables the preemption counter.
module reg_bus_arbiter #(
  parameter int pADDR_WIDTH   = 21,
  parameter int pBYTECNT_SIZE = 7,
  parameter int pWORD_BYTES   = 4
) (
  input  logic                                 usb_clk,
  input  logic                                 reset_n,
  input  logic [pADDR_WIDTH-pBYTECNT_SIZE-1:0] host_address,
  input  logic [pBYTECNT_SIZE-1:0]             host_bytecnt,
  input  logic [7:0]                           host_write_data,
  input  logic                                 host_read,
  input  logic                                 host_write,
  input  logic                                 host_addrvalid,
  output logic [7:0]                           host_read_data,
  input  logic                                 int_req,
  input  logic                                 int_we,
  input  logic [pADDR_WIDTH-pBYTECNT_SIZE-1:0] int_address,
  input  logic [8*pWORD_BYTES-1:0]             int_wdata,
  output logic                                 int_busy,
  output logic                                 int_ack,
  output logic [8*pWORD_BYTES-1:0]             int_rdata,
  output logic [pADDR_WIDTH-pBYTECNT_SIZE-1:0] reg_address,
  output logic [pBYTECNT_SIZE-1:0]             reg_bytecnt,
  output logic [7:0]                           reg_write_data,
  output logic                                 reg_read,
  output logic                                 reg_write,
  output logic                                 reg_addrvalid,
  input  logic [7:0]                           reg_read_data,
  output logic [15:0]                          preempt_count
);

  localparam int AW = pADDR_WIDTH - pBYTECNT_SIZE;
  localparam int DW = 8 * pWORD_BYTES;
  localparam int KW = 3;
  localparam logic [KW-1:0] K_LAST = KW'(pWORD_BYTES - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RUN  = 3'd1,
    S_LAST = 3'd2,
    S_ACK  = 3'd3,
    S_HOLD = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [KW-1:0]   k_q, k_d;
  logic            we_q, we_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic [DW-1:0]   acc_q, acc_d;
  logic [DW-1:0]   rdata_q, rdata_d;
  logic            busy_q, busy_d;
  logic            ack_q, ack_d;

  // Internal bus drive registers: hold the byte cycle the FSM issues next.
  logic [AW-1:0]            drv_address_q, drv_address_d;
  logic [pBYTECNT_SIZE-1:0] drv_bytecnt_q, drv_bytecnt_d;
  logic [7:0]               drv_wdata_q, drv_wdata_d;
  logic                     drv_read_q, drv_read_d;
  logic                     drv_write_q, drv_write_d;
  logic                     drv_addrvalid_q, drv_addrvalid_d;

  logic grant_host_s;

  // Next-state logic: sequence the word into bytes, capture read bytes, handle preemption.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    acc_d   = acc_q;
    case (state_q)
      S_IDLE: begin
        if (int_req && !host_addrvalid) begin
          we_d    = int_we;
          addr_d  = int_address;
          wdata_d = int_wdata;
          acc_d   = '0;
          k_d     = 3'd0;
          state_d = S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        if (host_addrvalid) begin
          // Host takes the bus; the partial word is thrown away and reissued.
          state_d = S_HOLD;
          k_d     = 3'd0;
          acc_d   = '0;
        end else begin
          // Bytes return in order, so shifting in from the top leaves byte 0 at the LSB.
          if (!we_q && (k_q != 3'd0)) begin
            acc_d = (acc_q >> 8) | (DW'(reg_read_data) << (DW - 8));
          end else begin
            acc_d = acc_q;
          end
          if (k_q == K_LAST) begin
            state_d = we_q ? S_ACK : S_LAST;
          end else begin
            k_d = k_q + 3'd1;
          end
        end
      end
      S_LAST: begin
        acc_d   = (acc_q >> 8) | (DW'(reg_read_data) << (DW - 8));
        state_d = S_ACK;
      end
      S_ACK: begin
        state_d = S_IDLE;
      end
      S_HOLD: begin
        if (!host_addrvalid) begin
          state_d = S_RUN;
          k_d     = 3'd0;
        end else begin
          state_d = S_HOLD;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Completion flags and the read word presented to the internal master.
  always_comb begin
    busy_d = (state_d != S_IDLE);
    ack_d  = (state_d == S_ACK);
    if (state_d == S_ACK) begin
      rdata_d = acc_d;
    end else begin
      rdata_d = rdata_q;
    end
  end

  // Bus drive values for the next cycle; only a RUN cycle drives the bus.
  always_comb begin
    if (state_d == S_RUN) begin
      drv_addrvalid_d = 1'b1;
      drv_address_d   = addr_d;
      drv_bytecnt_d   = pBYTECNT_SIZE'(k_d);
      drv_write_d     = we_d;
      drv_read_d      = !we_d;
      drv_wdata_d     = we_d ? 8'(wdata_d >> {k_d, 3'b000}) : 8'h00;
    end else begin
      drv_addrvalid_d = 1'b0;
      drv_address_d   = '0;
      drv_bytecnt_d   = '0;
      drv_write_d     = 1'b0;
      drv_read_d      = 1'b0;
      drv_wdata_d     = 8'h00;
    end
  end

  // State and drive registers with synchronous active-low reset.
  always_ff @(posedge usb_clk) begin
    if (!reset_n) begin
      state_q         <= S_IDLE;
      k_q             <= 3'd0;
      we_q            <= 1'b0;
      addr_q          <= '0;
      wdata_q         <= '0;
      acc_q           <= '0;
      rdata_q         <= '0;
      busy_q          <= 1'b0;
      ack_q           <= 1'b0;
      drv_address_q   <= '0;
      drv_bytecnt_q   <= '0;
      drv_wdata_q     <= 8'h00;
      drv_read_q      <= 1'b0;
      drv_write_q     <= 1'b0;
      drv_addrvalid_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      k_q             <= k_d;
      we_q            <= we_d;
      addr_q          <= addr_d;
      wdata_q         <= wdata_d;
      acc_q           <= acc_d;
      rdata_q         <= rdata_d;
      busy_q          <= busy_d;
      ack_q           <= ack_d;
      drv_address_q   <= drv_address_d;
      drv_bytecnt_q   <= drv_bytecnt_d;
      drv_wdata_q     <= drv_wdata_d;
      drv_read_q      <= drv_read_d;
      drv_write_q     <= drv_write_d;
      drv_addrvalid_q <= drv_addrvalid_d;
    end
  end

  // Bus mux: the host owns the bus whenever it asserts addrvalid or the FSM is idle.
  always_comb begin
    grant_host_s = host_addrvalid | (state_q == S_IDLE);
    if (grant_host_s) begin
      reg_address    = host_address;
      reg_bytecnt    = host_bytecnt;
      reg_write_data = host_write_data;
      reg_read       = host_read;
      reg_write      = host_write;
      reg_addrvalid  = host_addrvalid;
    end else begin
      reg_address    = drv_address_q;
      reg_bytecnt    = drv_bytecnt_q;
      reg_write_data = drv_wdata_q;
      reg_read       = drv_read_q;
      reg_write      = drv_write_q;
      reg_addrvalid  = drv_addrvalid_q;
    end
  end

  assign host_read_data = reg_read_data;
  assign int_busy       = busy_q;
  assign int_ack        = ack_q;
  assign int_rdata      = rdata_q;

`ifdef REG_ARB_PREEMPT_CNT_EN
  logic [15:0] pcnt_q, pcnt_d;

  // Count RUN->HOLD transitions, saturating at all-ones.
  always_comb begin
    if ((state_q == S_RUN) && host_addrvalid && (pcnt_q != 16'hFFFF)) begin
      pcnt_d = pcnt_q + 16'd1;
    end else begin
      pcnt_d = pcnt_q;
    end
  end

  // Preemption counter register.
  always_ff @(posedge usb_clk) begin
    if (!reset_n) begin
      pcnt_q <= 16'h0000;
    end else begin
      pcnt_q <= pcnt_d;
    end
  end

  assign preempt_count = pcnt_q;
`else
  assign preempt_count = 16'h0000;
`endif

endmodule
